// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for 4 requesters sharing one FIFO write port. Grant, strobe and data are registered, one cycle after the request.
// Backpressure: f_full, or f_afull while a write is in flight, stalls the grant and counts stall cycles.
module fifo_wr_arbiter #(
   parameter int DATA_W = 8,
   parameter int NREQ   = 4
) (
   input  logic                   wr_clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] req_data,
   input  logic                   f_full,
   input  logic                   f_afull,
   output logic                   wr_en,
   output logic [DATA_W-1:0]      wr_data,
   output logic [NREQ-1:0]        gnt,
   output logic [15:0]            stall_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t          state;
   logic [1:0]      last_gnt;
   logic [NREQ-1:0] elig;
   logic            blocked;
   logic            win_found;
   logic [1:0]      win;
   logic [1:0]      idx;

   // The requester written this cycle is excluded so a held req cannot win twice in a row.
   always_comb begin
      elig      = req & ~gnt;
      blocked   = f_full | ((state == WRITE) & f_afull);
      win       = 2'd0;
      win_found = 1'b0;
      idx       = 2'd0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = last_gnt + 2'(k);
         if (!win_found && elig[idx]) begin
            win       = idx;
            win_found = 1'b1;
         end
      end
   end

   always_ff @(posedge wr_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         wr_en     <= 1'b0;
         gnt       <= '0;
         wr_data   <= '0;
         stall_cnt <= 16'd0;
         last_gnt  <= 2'd3;
      end else if (win_found && !blocked) begin
         state    <= WRITE;
         wr_en    <= 1'b1;
         gnt      <= NREQ'(1) << win;
         wr_data  <= req_data[win*DATA_W +: DATA_W];
         last_gnt <= win;
      end else if (win_found) begin
         state <= STALL;
         wr_en <= 1'b0;
         gnt   <= '0;
         if (stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end else begin
         state <= IDLE;
         wr_en <= 1'b0;
         gnt   <= '0;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then randomized traffic, checked against a queue-free behavioural model.
module tb_fifo_wr_arbiter;
   localparam int DW = 8;

   logic          wr_clk = 1'b0;
   logic          reset  = 1'b1;
   logic [3:0]    req    = 4'b0000;
   logic [4*DW-1:0] req_data = '0;
   logic          f_full  = 1'b0;
   logic          f_afull = 1'b0;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic [3:0]    gnt;
   logic [15:0]   stall_cnt;

   int checks = 0;
   int errors = 0;

   bit       m_wr_en;
   bit [3:0] m_gnt;
   bit [7:0] m_data;
   int       m_last;
   int       m_stall;

   fifo_wr_arbiter #(.DATA_W(DW), .NREQ(4)) dut (
      .wr_clk   (wr_clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .f_full   (f_full),
      .f_afull  (f_afull),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .gnt      (gnt),
      .stall_cnt(stall_cnt)
   );

   always #5 wr_clk = ~wr_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_wr_en = 1'b0;
      m_gnt   = 4'b0000;
      m_data  = 8'h00;
      m_last  = 3;
      m_stall = 0;
   endtask

   // Rules applied directly: who is eligible, is the port blocked, who is next after the last winner.
   task automatic model_edge();
      int  winner;
      bit  blocked;
      winner  = -1;
      blocked = f_full || (m_wr_en && f_afull);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (m_last + k) % 4;
         if (winner < 0 && req[i] && !m_gnt[i]) winner = i;
      end
      if (winner >= 0 && !blocked) begin
         m_wr_en = 1'b1;
         m_gnt   = 4'b0001 << winner;
         m_data  = req_data[winner*DW +: DW];
         m_last  = winner;
      end else begin
         if (winner >= 0 && m_stall < 65535) m_stall++;
         m_wr_en = 1'b0;
         m_gnt   = 4'b0000;
      end
   endtask

   task automatic compare_all(input string tag);
      check_val({tag, "_wr_en"}, 32'(wr_en), 32'(m_wr_en));
      check_val({tag, "_gnt"}, 32'(gnt), 32'(m_gnt));
      check_val({tag, "_wr_data"}, 32'(wr_data), 32'(m_data));
      check_val({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
      check_val({tag, "_onehot"}, 32'($countones(gnt) > 1), 32'd0);
      check_val({tag, "_gnt_no_wr"}, 32'((gnt != 4'b0000) && !wr_en), 32'd0);
   endtask

   task automatic cyc(input logic [3:0] r, input logic ff, input logic af, input string tag);
      req     = r;
      f_full  = ff;
      f_afull = af;
      @(posedge wr_clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   // Reset lands between edges; outputs must clear without waiting for a clock.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      compare_all(tag);
      @(posedge wr_clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] nr;
      #1;
      model_reset();
      compare_all("por");
      @(posedge wr_clk);
      #1;
      reset = 1'b0;

      // Single requester, one-cycle latency, strobe drops once req is released
      req_data[7:0] = 8'hA5;
      cyc(4'b0001, 1'b0, 1'b0, "single");
      check_val("single_gnt_const", 32'(gnt), 32'h1);
      check_val("single_data_const", 32'(wr_data), 32'hA5);
      cyc(4'b0000, 1'b0, 1'b0, "single_drop");
      check_val("single_drop_wr_en", 32'(wr_en), 32'd0);

      // All four request, each releases after its own grant
      do_reset("rst_all4");
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      cyc(4'b1111, 1'b0, 1'b0, "all4_a");
      check_val("all4_a_const", 32'(gnt), 32'h1);
      cyc(4'b1110, 1'b0, 1'b0, "all4_b");
      check_val("all4_b_const", 32'(gnt), 32'h2);
      cyc(4'b1100, 1'b0, 1'b0, "all4_c");
      check_val("all4_c_const", 32'(gnt), 32'h4);
      cyc(4'b1000, 1'b0, 1'b0, "all4_d");
      check_val("all4_d_const", 32'(gnt), 32'h8);

      // Two requesters re-requesting forever alternate
      do_reset("rst_alt");
      for (int n = 0; n < 6; n++) begin
         cyc(4'b0011, 1'b0, 1'b0, "alt");
         check_val("alt_const", 32'(gnt), (n % 2 == 0) ? 32'h1 : 32'h2);
      end

      // FIFO full for 10 cycles, then release
      do_reset("rst_full");
      for (int n = 0; n < 10; n++) cyc(4'b0100, 1'b1, 1'b0, "full");
      check_val("full_stall_const", 32'(stall_cnt), 32'd10);
      cyc(4'b0100, 1'b0, 1'b0, "full_release");
      check_val("full_release_gnt", 32'(gnt), 32'h4);

      // Almost-full while writing blocks the next grant
      do_reset("rst_afull");
      cyc(4'b0011, 1'b0, 1'b0, "afull_a");
      cyc(4'b0011, 1'b0, 1'b1, "afull_b");
      check_val("afull_wr_en_const", 32'(wr_en), 32'd0);
      check_val("afull_stall_const", 32'(stall_cnt), 32'd1);

      // Withdrawn request while stalled is silently dropped
      do_reset("rst_wd");
      cyc(4'b0100, 1'b1, 1'b0, "wd_a");
      cyc(4'b0000, 1'b0, 1'b0, "wd_b");
      check_val("wd_gnt_const", 32'(gnt), 32'h0);

      // Reset mid-grant, requester 0 wins after release
      do_reset("rst_mid0");
      cyc(4'b0011, 1'b0, 1'b0, "mid_a");
      cyc(4'b0011, 1'b0, 1'b0, "mid_b");
      check_val("mid_b_const", 32'(gnt), 32'h2);
      do_reset("rst_mid");
      cyc(4'b0011, 1'b0, 1'b0, "mid_after");
      check_val("mid_after_const", 32'(gnt), 32'h1);

      // Randomized traffic against the model
      do_reset("rst_rand");
      for (int n = 0; n < 400; n++) begin
         nr = req;
         for (int i = 0; i < 4; i++) begin
            if (!req[i]) begin
               nr[i] = ($urandom_range(0, 1) == 1);
               req_data[i*DW +: DW] = 8'($urandom);
            end else if (gnt[i]) begin
               nr[i] = ($urandom_range(0, 2) != 0);
            end else begin
               nr[i] = ($urandom_range(0, 7) != 0);
            end
         end
         if (n % 137 == 100) do_reset("rand_rst");
         cyc(nr, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each requester's write data.
REQ-002 SHALL have parameter NREQ, fixed at 4, number of requesters sharing the FIFO write port.
REQ-003 SHALL have port wr_clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, 4, per-requester write request, level, held until granted.
REQ-006 SHALL have port req_data, input, 4*DATA_W, requester i data on bits [i*DATA_W +: DATA_W], stable while req[i] is high.
REQ-007 SHALL have port f_full, input, 1, FIFO full flag from the write domain.
REQ-008 SHALL have port f_afull, input, 1, FIFO has exactly one free entry.
REQ-009 SHALL have port wr_en, output, 1, registered FIFO write strobe.
REQ-010 SHALL have port wr_data, output, DATA_W, registered write data, valid when wr_en=1.
REQ-011 SHALL have port gnt, output, 4, registered one-hot acknowledge, high in the same cycle as the corresponding write.
REQ-012 SHALL have port stall_cnt, output, 16, saturating count of stall cycles.

Function
REQ-013 SHALL implement three states: IDLE (no write, no pending work), WRITE (wr_en=1), STALL (at least one eligible request, grant blocked by FIFO status).
REQ-014 SHALL compute eligibility at each edge: req[i]=1 and gnt[i]=0, so the requester granted this cycle is excluded from the next decision.
REQ-015 SHALL treat the grant as blocked when f_full=1, or when wr_en=1 and f_afull=1.
REQ-016 SHALL, when any requester is eligible and the grant is not blocked, go to WRITE next cycle and assert wr_en=1, gnt one-hot for the winner, and wr_data from the winner's req_data.
REQ-017 SHALL select the winner round-robin: the search starts at (last_gnt+1) mod 4, ascending with wrap.
REQ-018 SHALL update last_gnt only when a grant is issued.
REQ-019 SHALL go to STALL when any requester is eligible and the grant is blocked, and to IDLE when no requester is eligible.
REQ-020 SHALL allow consecutive grants, giving one write per cycle when f_full=0 and f_afull=0.
REQ-021 SHALL keep wr_en=0 and gnt=0 in IDLE and STALL, and SHALL hold wr_data at its last value.
REQ-022 SHALL never assert more than one gnt bit at a time, and SHALL never assert gnt without wr_en.
REQ-023 SHALL increment stall_cnt by 1 on each edge taken in STALL, saturate at 16'hFFFF, and never wrap.
REQ-024 SHALL ignore a request that is withdrawn before it is granted, with no grant issued and no error.
REQ-025 SHALL have a latency of one cycle: a request sampled at edge k with the grant unblocked appears as wr_en and gnt at edge k+1.

Reset
REQ-026 SHALL, when reset=1 (asynchronous, without waiting for a clock edge), force state=IDLE, wr_en=0, gnt=4'b0000, wr_data=0, stall_cnt=0, and last_gnt=3 so requester 0 has first priority.
REQ-027 SHALL abandon any in-flight grant on reset, issue no write for it, and expect the requester to keep req high and be re-arbitrated after reset releases.
REQ-028 SHALL make its first grant at the first rising edge after reset falls at which an eligible request is present and the grant is not blocked.

Verification
REQ-029 SHALL be checked with: reset, then req=4'b0001 and req_data[7:0]=8'hA5 -> next cycle wr_en=1, gnt=4'b0001, wr_data=8'hA5; requester drops req, and the following cycle wr_en=0.
REQ-030 SHALL be checked with: req=4'b1111 held with each requester releasing after its own gnt, f_full=0 -> grants 0001, 0010, 0100, 1000 on four consecutive cycles, one-hot, no gaps.
REQ-031 SHALL be checked with: req=4'b0011 with both requesters re-requesting after each gnt -> gnt alternates 0001, 0010, 0001 ...; neither requester is granted twice in a row.
REQ-032 SHALL be checked with: f_full=1 for 10 cycles with req=4'b0100 -> wr_en=0 throughout, stall_cnt=10; when f_full falls, gnt=4'b0100 one cycle later.
REQ-033 SHALL be checked with: a cycle where wr_en=1 and f_afull=1 while another requester is pending -> wr_en=0 in the next cycle and state=STALL.
REQ-034 SHALL be checked with: reset asserted mid-cycle while gnt=4'b0010 -> wr_en, gnt and stall_cnt go to 0 immediately; after release, requester 0 wins if req=4'b0011.
